bcd_operand_entry: RTL



---
 rtl/bcd_operand_entry_if.sv | 18 +
 rtl/bcd_operand_entry.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_entry_if.sv
// rtl/bcd_operand_entry_if.sv - commit handshake bundle from the entry block to the operand store
//
// Signals:
//   commit_valid  one-clk pulse announcing a committed operand
//   commit_data   two's-complement operand value, valid with commit_valid
//   commit_idx    operand slot the value belongs to
// Modports: master (entry block drives), slave (BRAM writer samples).
interface bcd_operand_entry_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 1
);
    logic              commit_valid;
    logic [DATA_W-1:0] commit_data;
    logic [IDX_W-1:0]  commit_idx;

    modport master (output commit_valid, commit_data, commit_idx);
    modport slave  (input  commit_valid, commit_data, commit_idx);
endinterface

// File: rtl/bcd_operand_entry.sv
// rtl/bcd_operand_entry.sv - button-driven signed BCD operand entry with commit handshake
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   bt_c/u/d/l/r          raw buttons: commit, up, down, cursor left, cursor right
//   value_out             registered two's-complement value of the current entry
//   digits_out            BCD digits, ones digit in [3:0]
//   sign_out              1 = negative
//   cursor_out            selected position, NUM_DIGITS = sign position
//   operand_idx           operand slot being edited
//   commit_if (master)    commit_valid / commit_data / commit_idx pulse
// Optional feature macro: AUTOREPEAT_EN (held U/D auto-repeat).
module bcd_operand_entry #(
    parameter int NUM_DIGITS     = 3,
    parameter int NUM_OPERANDS   = 2,
    parameter int DATA_W         = 16,
    parameter int TICK_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_RATE    = 100,
    localparam int CUR_W = ($clog2(NUM_DIGITS + 1) > 1) ? $clog2(NUM_DIGITS + 1) : 1,
    localparam int IDX_W = ($clog2(NUM_OPERANDS) > 1) ? $clog2(NUM_OPERANDS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bt_c,
    input  logic                    bt_u,
    input  logic                    bt_d,
    input  logic                    bt_l,
    input  logic                    bt_r,
    output logic [DATA_W-1:0]       value_out,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    sign_out,
    output logic [CUR_W-1:0]        cursor_out,
    output logic [IDX_W-1:0]        operand_idx,
    bcd_operand_entry_if.master     commit_if
);
    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int k = 0; k < n; k++) r = r * 10;
        return r;
    endfunction

    localparam longint MAX_MAG = pow10(NUM_DIGITS) - 1;
    localparam int TDW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);

    generate
        if (MAX_MAG >= (longint'(1) << (DATA_W - 1))) begin : g_width_check
            $error("DATA_W too narrow for NUM_DIGITS magnitude");
        end
    endgenerate

    // Sample tick
    logic [TDW-1:0] tick_cnt_q;
    logic           tick;
    assign tick = (tick_cnt_q == TDW'(TICK_DIV - 1));

    // Button path, bit order {C, L, R, U, D}
    logic [4:0]     raw, sync1_q, sync2_q, deb_q, deb_prev_q, press;
    logic [DBW-1:0] dbc_q [5];
    assign raw   = {bt_c, bt_l, bt_r, bt_u, bt_d};
    assign press = deb_q & ~deb_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int b = 0; b < 5; b++) dbc_q[b] <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (tick) begin
                for (int b = 0; b < 5; b++) begin
                    if (sync2_q[b] == deb_q[b]) begin
                        dbc_q[b] <= '0;
                    end else if (dbc_q[b] == DBW'(DEBOUNCE_TICKS - 1)) begin
                        deb_q[b] <= sync2_q[b];
                        dbc_q[b] <= '0;
                    end else begin
                        dbc_q[b] <= dbc_q[b] + 1'b1;
                    end
                end
            end
        end
    end

    // Entry state
    logic [3:0]        digits_q [NUM_DIGITS];
    logic [3:0]        digits_d [NUM_DIGITS];
    logic              sign_q, sign_d;
    logic [CUR_W-1:0]  cursor_q, cursor_d;
    logic [IDX_W-1:0]  op_idx_q, op_idx_d;
    logic [DATA_W-1:0] value_q, value_d, mag;
    logic              commit_valid_q, commit_valid_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic [IDX_W-1:0]  commit_idx_q, commit_idx_d;
    logic              at_sign, rep_up, rep_dn;
    logic              ev_c, ev_l, ev_r, ev_u, ev_d;

    assign at_sign = (cursor_q == CUR_W'(NUM_DIGITS));

`ifdef AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW    = $clog2(RP_MAX + 1);
    logic [RPW-1:0] rep_cnt_q;
    logic           rep_phase_q;   // 0 = waiting initial delay, 1 = repeating
    logic           held, rep_hit;
    assign held    = deb_q[1] | deb_q[0];
    assign rep_hit = tick && held &&
                     (rep_phase_q ? (rep_cnt_q == RPW'(REPEAT_RATE - 1))
                                  : (rep_cnt_q == RPW'(REPEAT_DELAY - 1)));
    // Still counted at the sign position, but never fired there so the sign toggles once.
    assign rep_up  = rep_hit && !at_sign && deb_q[1];
    assign rep_dn  = rep_hit && !at_sign && !deb_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else if ((|press) || !held) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else if (tick) begin
            if (rep_hit) begin
                rep_cnt_q   <= '0;
                rep_phase_q <= 1'b1;
            end else begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
            end
        end
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign ev_c = press[4];
    assign ev_l = press[3];
    assign ev_r = press[2];
    assign ev_u = press[1] | rep_up;
    assign ev_d = press[0] | rep_dn;

    // Priority C > L > R > U > D; lower events in the same clk are dropped.
    always_comb begin
        digits_d       = digits_q;
        sign_d         = sign_q;
        cursor_d       = cursor_q;
        op_idx_d       = op_idx_q;
        commit_valid_d = 1'b0;
        commit_data_d  = commit_data_q;
        commit_idx_d   = commit_idx_q;
        if (ev_c) begin
            commit_valid_d = 1'b1;
            commit_data_d  = value_q;
            commit_idx_d   = op_idx_q;
            for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = 4'd0;
            sign_d   = 1'b0;
            cursor_d = '0;
            op_idx_d = (op_idx_q == IDX_W'(NUM_OPERANDS - 1)) ? '0 : op_idx_q + 1'b1;
        end else if (ev_l) begin
            cursor_d = at_sign ? '0 : cursor_q + 1'b1;
        end else if (ev_r) begin
            cursor_d = (cursor_q == '0) ? CUR_W'(NUM_DIGITS) : cursor_q - 1'b1;
        end else if (ev_u || ev_d) begin
            if (at_sign) begin
                sign_d = ~sign_q;
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cursor_q == CUR_W'(i)) begin
                        if (ev_u && digits_q[i] != 4'd9)
                            digits_d[i] = digits_q[i] + 4'd1;
                        else if (!ev_u && digits_q[i] != 4'd0)
                            digits_d[i] = digits_q[i] - 4'd1;
                    end
                end
            end
        end
    end

    // Negative zero naturally maps to 0 through the two's-complement negate.
    always_comb begin
        mag = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            mag = mag + DATA_W'(digits_q[i]) * DATA_W'(pow10(i));
        value_d = sign_q ? (~mag + 1'b1) : mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 4'd0;
            sign_q         <= 1'b0;
            cursor_q       <= '0;
            op_idx_q       <= '0;
            value_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_data_q  <= '0;
            commit_idx_q   <= '0;
        end else begin
            digits_q       <= digits_d;
            sign_q         <= sign_d;
            cursor_q       <= cursor_d;
            op_idx_q       <= op_idx_d;
            value_q        <= value_d;
            commit_valid_q <= commit_valid_d;
            commit_data_q  <= commit_data_d;
            commit_idx_q   <= commit_idx_d;
        end
    end

    always_comb begin
        digits_out = '0;
        for (int i = 0; i < NUM_DIGITS; i++) digits_out[4*i +: 4] = digits_q[i];
    end

    assign value_out              = value_q;
    assign sign_out               = sign_q;
    assign cursor_out             = cursor_q;
    assign operand_idx            = op_idx_q;
    assign commit_if.commit_valid = commit_valid_q;
    assign commit_if.commit_data  = commit_data_q;
    assign commit_if.commit_idx   = commit_idx_q;
endmodule
